vliw_ctrl_decoder: RTL and testbench
====================================

# vliw_ctrl_decoder

Parametrised, pipelined control decoder for the VLIW issue stage. It accepts one instruction bundle per cycle: NUM_ALU ALU slots, one multiply slot and one load/store slot. It emits a registered control word to the execute stage over a valid/ready handshake. It stalls issue while a multi-cycle multiply is outstanding, and it converts illegal bundles to NOPs while latching a sticky, per-slot error record.

## Interface
Parameters:
- NUM_ALU, 2: number of ALU slots, 1..8.
- OPC_W, 5: opcode width per slot.
- MUL_LAT, 3: multiply latency in cycles, 1..15.
- CTRL_W, 5*NUM_ALU+4: derived control-word width; do not override.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  bundle present.
- in_ready  out  1  decoder can accept a bundle.
- alu_opc  in  NUM_ALU*OPC_W  ALU opcodes; slot 0 in the MSBs.
- m_opc  in  OPC_W  multiply-slot opcode.
- ls_opc  in  OPC_W  load/store-slot opcode.
- out_valid  out  1  control word valid.
- out_ready  in  1  execute stage accepts the word.
- control  out  CTRL_W  per ALU slot i, MSB first: {imm_sel_i, alu_op_i[3:0]}; then m_imm_sel, m_en, ld_en, st_en.
- busy  out  1  multiply stall in progress.
- err  out  1  sticky illegal-opcode flag.
- err_slot  out  NUM_ALU+2  slot mask of the first faulting bundle: ALU slots in bits [NUM_ALU+1:2], M in bit 1, LS in bit 0.
- err_clr  in  1  clears err and err_slot.

## Operation
Slot decode:
- **ALU slot.** 5'h00 is NOP, with all fields 0. 5'h01–5'h0B are legal, with alu_op = opc[3:0]. imm_sel = 1 for 5'h08–5'h0B. All other values are illegal.
- **M slot.** 5'h00 and 5'h0C are NOP. 5'h0D is MUL (m_en = 1). 5'h0E is MULI (m_en = 1, m_imm_sel = 1). All other values are illegal.
- **LS slot.** 5'h00 is NOP. 5'h10 is store (st_en = 1). 5'h11 is load (ld_en = 1). All other values are illegal.

Error handling:
- If any slot is illegal, the whole bundle is emitted as an all-zero control word. It is still handed off with out_valid.
- On an accepted illegal bundle while err = 0: set err and load err_slot with the faulting-slot mask.
- While err = 1, later errors leave err_slot unchanged.
- If err_clr and a new error occur in the same cycle, the new error wins: err = 1 and err_slot holds the new mask.

State machine (RUN, MUL_WAIT):
- **RUN.** in_ready = !out_valid || out_ready. Accepting a legal bundle with m_en = 1 when MUL_LAT > 1 loads stall_cnt with MUL_LAT-1 and moves to MUL_WAIT.
- **MUL_WAIT.** in_ready = 0 and busy = 1. stall_cnt decrements each cycle. When stall_cnt reaches 1 and then decrements, the state returns to RUN. The output register still drains normally in this state.
- A bundle is accepted on in_valid && in_ready.
- The output register holds its value while out_valid && !out_ready.
- Illegal bundles never enter MUL_WAIT.

## Timing
- Latency: accept in cycle N, then control and out_valid are valid in cycle N+1.
- Throughput: 1 bundle/cycle with no multiplies; a multiply bundle costs MUL_LAT cycles of issue.
- in_ready is combinational from state, out_valid and out_ready only, never from in_valid. in_ready is 0 while rst_n = 0.
- Reset values: out_valid 0, control 0, busy 0, err 0, err_slot 0, state RUN, stall_cnt 0.
- Reset asserted mid-stall aborts MUL_WAIT and drops any pending output word.
- Back-to-back multiplies: the second bundle is accepted exactly MUL_LAT cycles after the first.

## Configuration
Macro: CTRL_MUL_STALL_EN.
- **Defined:** MUL_WAIT and stall_cnt exist, and the behaviour is as described above.
- **Undefined:** the multiply is treated as single-cycle. The FSM is absent, busy is tied 0, and in_ready = !out_valid || out_ready always. MUL_LAT is ignored.

## Structure
- Package ctrl_pkg holds:
  - opcode constants: OPC_NOP, OPC_ALU_MAX, OPC_IMM_MIN, OPC_MNOP, OPC_MUL, OPC_MULI, OPC_ST, OPC_LD;
  - ALU_OP_W = 4 and SLOT_CTRL_W = 5;
  - the state enum ctrl_state_e {RUN, MUL_WAIT}.
- Sub-module alu_slot_dec: purely combinational, OPC_W in, and {imm_sel, alu_op, illegal} out. It is instantiated NUM_ALU times by a generate loop.

## Test plan
- **Basic decode.** NUM_ALU = 2, alu_opc = {5'h03, 5'h09}, m_opc = 5'h0C, ls_opc = 5'h11 → next cycle control = 14'b0_0011_1_1001_0010, out_valid = 1.
- **Multiply stall.** MULI bundle accepted at cycle 0 with MUL_LAT = 3 → busy = 1 and in_ready = 0 in cycles 1–2; the next bundle is accepted in cycle 3.
- **Illegal slot.** alu_opc slot 1 = 5'h1F, ls_opc = 5'h12 → control = 0, out_valid = 1, err = 1, err_slot = 4'b0101. A later illegal M bundle leaves err_slot unchanged.
- **Simultaneous clear and error.** err_clr = 1 in the same cycle as an illegal M bundle → err = 1, err_slot = 4'b0010.
- **Backpressure.** out_ready held 0 for 4 cycles → control stable and in_ready = 0; the next bundle is accepted in the cycle out_ready returns to 1.
- **Reset mid-stall.** rst_n = 0 for one cycle during MUL_WAIT → all outputs 0, state RUN, in_ready = 1 after release; repeat with CTRL_MUL_STALL_EN undefined → busy never asserts.

Source files
------------

// File: rtl/vliw_ctrl_decoder_pkg.sv
// Shared opcode constants, slot-control widths and FSM state type for the VLIW issue-stage decoder.
package ctrl_pkg;

    localparam int ALU_OP_W    = 4;
    localparam int SLOT_CTRL_W = 5;

    localparam logic [4:0] OPC_NOP     = 5'h00;
    localparam logic [4:0] OPC_ALU_MAX = 5'h0B;
    localparam logic [4:0] OPC_IMM_MIN = 5'h08;
    localparam logic [4:0] OPC_MNOP    = 5'h0C;
    localparam logic [4:0] OPC_MUL     = 5'h0D;
    localparam logic [4:0] OPC_MULI    = 5'h0E;
    localparam logic [4:0] OPC_ST      = 5'h10;
    localparam logic [4:0] OPC_LD      = 5'h11;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/vliw_ctrl_decoder_if.sv
// Issue-side bundle handshake, execute-side control handshake and error-record signals of the decoder.
interface vliw_ctrl_decoder_if #(
    parameter int NUM_ALU = 2,
    parameter int OPC_W   = 5
);
    localparam int CTRL_W = 5 * NUM_ALU + 4;

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_ALU*OPC_W-1:0] alu_opc;
    logic [OPC_W-1:0]         m_opc;
    logic [OPC_W-1:0]         ls_opc;
    logic                     out_valid;
    logic                     out_ready;
    logic [CTRL_W-1:0]        control;
    logic                     busy;
    logic                     err;
    logic [NUM_ALU+1:0]       err_slot;
    logic                     err_clr;

    modport slave (
        input  in_valid, alu_opc, m_opc, ls_opc, out_ready, err_clr,
        output in_ready, out_valid, control, busy, err, err_slot
    );

    modport master (
        output in_valid, alu_opc, m_opc, ls_opc, out_ready, err_clr,
        input  in_ready, out_valid, control, busy, err, err_slot
    );

endinterface

// File: rtl/vliw_ctrl_decoder_alu_slot_dec.sv
// Combinational decode of one ALU slot opcode into {imm_sel, alu_op} plus an illegal flag.
module alu_slot_dec
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0]    opc_i,
    output logic                imm_sel_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o
);

    always_comb begin
        imm_sel_o = 1'b0;
        alu_op_o  = '0;
        illegal_o = 1'b0;
        if (opc_i != OPC_W'(OPC_NOP) && opc_i <= OPC_W'(OPC_ALU_MAX)) begin
            alu_op_o  = opc_i[ALU_OP_W-1:0];
            imm_sel_o = (opc_i >= OPC_W'(OPC_IMM_MIN));
        end else if (opc_i != OPC_W'(OPC_NOP)) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/vliw_ctrl_decoder.sv
// VLIW issue-stage control decoder: registered control word, sticky error record, optional multiply stall.
// Macro CTRL_MUL_STALL_EN enables the multiply stall FSM; when undefined multiplies are single-cycle.
//   state    | meaning
//   RUN      | issue open whenever the output register can take a word
//   MUL_WAIT | multiply outstanding, issue blocked until stall_cnt expires
module vliw_ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int NUM_ALU = 2,
    parameter int OPC_W   = 5,
    parameter int MUL_LAT = 3,
    parameter int CTRL_W  = 5 * NUM_ALU + 4
) (
    input logic                 clk,
    input logic                 rst_n,
    vliw_ctrl_decoder_if.slave  bus
);

    if (NUM_ALU < 1 || NUM_ALU > 8 || MUL_LAT < 1 || MUL_LAT > 15 ||
        CTRL_W != SLOT_CTRL_W * NUM_ALU + 4) begin : g_param_chk
        $error("vliw_ctrl_decoder: parameter out of range");
    end

    logic [NUM_ALU-1:0]  alu_imm;
    logic [NUM_ALU-1:0]  alu_ill;
    logic [ALU_OP_W-1:0] alu_op [NUM_ALU];

    for (genvar i = 0; i < NUM_ALU; i++) begin : g_alu
        alu_slot_dec #(.OPC_W(OPC_W)) u_dec (
            .opc_i     (bus.alu_opc[(NUM_ALU-i)*OPC_W-1 -: OPC_W]),
            .imm_sel_o (alu_imm[i]),
            .alu_op_o  (alu_op[i]),
            .illegal_o (alu_ill[i])
        );
    end

    logic m_en, m_imm_sel, m_ill;
    logic ld_en, st_en, ls_ill;

    always_comb begin
        m_en      = 1'b0;
        m_imm_sel = 1'b0;
        m_ill     = 1'b0;
        case (bus.m_opc)
            OPC_W'(OPC_NOP), OPC_W'(OPC_MNOP): begin
            end
            OPC_W'(OPC_MUL): m_en = 1'b1;
            OPC_W'(OPC_MULI): begin
                m_en      = 1'b1;
                m_imm_sel = 1'b1;
            end
            default: m_ill = 1'b1;
        endcase
    end

    always_comb begin
        ld_en  = 1'b0;
        st_en  = 1'b0;
        ls_ill = 1'b0;
        case (bus.ls_opc)
            OPC_W'(OPC_NOP): begin
            end
            OPC_W'(OPC_ST): st_en = 1'b1;
            OPC_W'(OPC_LD): ld_en = 1'b1;
            default:        ls_ill = 1'b1;
        endcase
    end

    logic [CTRL_W-1:0]  ctrl_word;
    logic [NUM_ALU+1:0] err_mask;
    logic               any_ill;

    // Slot 0 occupies the most significant position in both the control word and the error mask.
    always_comb begin
        ctrl_word = '0;
        err_mask  = '0;
        for (int i = 0; i < NUM_ALU; i++) begin
            ctrl_word[CTRL_W-1-SLOT_CTRL_W*i -: SLOT_CTRL_W] = {alu_imm[i], alu_op[i]};
            err_mask[NUM_ALU+1-i] = alu_ill[i];
        end
        ctrl_word[3:0] = {m_imm_sel, m_en, ld_en, st_en};
        err_mask[1]    = m_ill;
        err_mask[0]    = ls_ill;
    end

    assign any_ill = |err_mask;

    logic               out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]  control_q, control_d;
    logic               err_q, err_d;
    logic [NUM_ALU+1:0] err_slot_q, err_slot_d;
    logic               in_ready;
    logic               busy;
    logic               accept;

    assign accept = bus.in_valid && in_ready;

`ifdef CTRL_MUL_STALL_EN
    ctrl_state_e state_q, state_d;
    logic [3:0]  stall_cnt_q, stall_cnt_d;

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (state_q == MUL_WAIT) begin
            busy = 1'b1;
        end else begin
            in_ready = rst_n && (!out_valid_q || bus.out_ready);
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (accept && !any_ill && m_en && MUL_LAT > 1) begin
                    state_d     = MUL_WAIT;
                    stall_cnt_d = 4'(MUL_LAT - 1);
                end
            end
            MUL_WAIT: begin
                stall_cnt_d = stall_cnt_q - 4'd1;
                if (stall_cnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign busy     = 1'b0;
    assign in_ready = rst_n && (!out_valid_q || bus.out_ready);
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        control_d   = control_q;
        if (accept) begin
            out_valid_d = 1'b1;
            control_d   = any_ill ? '0 : ctrl_word;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A clear in the same cycle as a new fault lets the new fault's mask through.
        err_d      = err_q;
        err_slot_d = err_slot_q;
        if (bus.err_clr) begin
            err_d      = 1'b0;
            err_slot_d = '0;
        end
        if (accept && any_ill && !err_d) begin
            err_d      = 1'b1;
            err_slot_d = err_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            control_q   <= '0;
            err_q       <= 1'b0;
            err_slot_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            control_q   <= control_d;
            err_q       <= err_d;
            err_slot_q  <= err_slot_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_q;
    assign bus.control   = control_q;
    assign bus.err       = err_q;
    assign bus.err_slot  = err_slot_q;

endmodule

// File: tb/tb_vliw_ctrl_decoder.sv
// Directed self-checking bench for vliw_ctrl_decoder (NUM_ALU=2, MUL_LAT=3); follows CTRL_MUL_STALL_EN.
module tb_vliw_ctrl_decoder;

`ifdef CTRL_MUL_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    vliw_ctrl_decoder_if #(.NUM_ALU(2), .OPC_W(5)) bus ();

    vliw_ctrl_decoder #(.NUM_ALU(2), .OPC_W(5), .MUL_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] alu, input logic [4:0] m, input logic [4:0] ls,
                         input logic v);
        bus.alu_opc  = alu;
        bus.m_opc    = m;
        bus.ls_opc   = ls;
        bus.in_valid = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_control",   32'(bus.control),   32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_err_slot",  32'(bus.err_slot),  32'd0);

        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // basic decode
        drive({5'h03, 5'h09}, 5'h0C, 5'h11, 1'b1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("basic_ctrl",  32'(bus.control),   32'(14'b0_0011_1_1001_0010));
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_err",   32'(bus.err),       32'd0);
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // MULI, next bundle waiting behind it
        drive({5'h0B, 5'h00}, 5'h0E, 5'h10, 1'b1);
        step();
        drive({5'h01, 5'h02}, 5'h00, 5'h00, 1'b1);
        chk("muli_ctrl",     32'(bus.control),  32'(14'b1_1011_0_0000_1101));
        chk("muli_busy",     32'(bus.busy),     32'(STALL));
        chk("muli_in_ready", 32'(bus.in_ready), 32'(!STALL));
`ifdef CTRL_MUL_STALL_EN
        step();
        chk("stall_busy_c2",  32'(bus.busy),      32'd1);
        chk("stall_ready_c2", 32'(bus.in_ready),  32'd0);
        chk("stall_valid_c2", 32'(bus.out_valid), 32'd0);
        step();
        chk("stall_busy_c3",  32'(bus.busy),     32'd0);
        chk("stall_ready_c3", 32'(bus.in_ready), 32'd1);
`endif
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("post_mul_ctrl",  32'(bus.control),   32'(14'b0_0001_0_0010_0000));
        chk("post_mul_valid", 32'(bus.out_valid), 32'd1);
        chk("post_mul_busy",  32'(bus.busy),      32'd0);

        // immediate-range boundary, legal
        drive({5'h08, 5'h07}, 5'h00, 5'h00, 1'b1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("imm_bound_ctrl", 32'(bus.control), 32'(14'b1_1000_0_0111_0000));
        chk("imm_bound_err",  32'(bus.err),     32'd0);

        // illegal ALU slot 1 and LS slot
        drive({5'h05, 5'h1F}, 5'h00, 5'h12, 1'b1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("ill_ctrl",  32'(bus.control),   32'd0);
        chk("ill_valid", 32'(bus.out_valid), 32'd1);
        chk("ill_err",   32'(bus.err),       32'd1);
        chk("ill_slot",  32'(bus.err_slot),  32'(4'b0101));

        // later illegal M leaves the record alone
        drive({5'h00, 5'h00}, 5'h0F, 5'h00, 1'b1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("illm_ctrl",  32'(bus.control),   32'd0);
        chk("illm_valid", 32'(bus.out_valid), 32'd1);
        chk("illm_slot",  32'(bus.err_slot),  32'(4'b0101));

        // clear and new fault together
        drive({5'h00, 5'h00}, 5'h13, 5'h00, 1'b1);
        bus.err_clr = 1'b1;
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        bus.err_clr = 1'b0;
        chk("clr_new_err",  32'(bus.err),      32'd1);
        chk("clr_new_slot", 32'(bus.err_slot), 32'(4'b0010));

        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        chk("clear_err",  32'(bus.err),      32'd0);
        chk("clear_slot", 32'(bus.err_slot), 32'd0);

        // 5'h0C is just past the ALU range
        drive({5'h0C, 5'h01}, 5'h00, 5'h00, 1'b1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("alu0c_ctrl", 32'(bus.control),  32'd0);
        chk("alu0c_slot", 32'(bus.err_slot), 32'(4'b1000));
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;

        // backpressure
        bus.out_ready = 1'b0;
        drive({5'h01, 5'h02}, 5'h00, 5'h00, 1'b1);
        step();
        drive({5'h03, 5'h04}, 5'h00, 5'h00, 1'b1);
        chk("bp_ctrl0",  32'(bus.control),  32'(14'b0_0001_0_0010_0000));
        chk("bp_ready0", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_ctrl",  32'(bus.control),   32'(14'b0_0001_0_0010_0000));
            chk("bp_hold_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(bus.in_ready), 32'd1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("bp_new_ctrl",  32'(bus.control),   32'(14'b0_0011_0_0100_0000));
        chk("bp_new_valid", 32'(bus.out_valid), 32'd1);
        step();

        // reset during the multiply stall
        drive({5'h00, 5'h00}, 5'h0D, 5'h00, 1'b1);
        step();
        drive(10'h000, 5'h00, 5'h00, 1'b0);
        chk("rs_mul_ctrl", 32'(bus.control),   32'(14'b0_0000_0_0000_0100));
        chk("rs_busy_pre", 32'(bus.busy),      32'(STALL));
        rst_n = 1'b0;
        #1;
        chk("rs_in_ready_low", 32'(bus.in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rs_valid",    32'(bus.out_valid), 32'd0);
        chk("rs_ctrl",     32'(bus.control),   32'd0);
        chk("rs_busy",     32'(bus.busy),      32'd0);
        chk("rs_err",      32'(bus.err),       32'd0);
        chk("rs_in_ready", 32'(bus.in_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
